// File: rtl/residual_ln_stats_if.sv
// Handshake bundle: residual beats in, per-token LayerNorm statistics out.
// slave: stats stage side; master: adder-array / LayerNorm side.
interface residual_ln_stats_if #(
  parameter int ADDER_NUM = 128,
  parameter int DIMENTION = 768,
  parameter int WIDTH_SUM = 32,
  parameter int LANES     = 16
);
  localparam int WIDTH_S = WIDTH_SUM + $clog2(DIMENTION);
  localparam int WIDTH_Q = 2 * WIDTH_SUM + $clog2(DIMENTION);
  localparam int TW = (ADDER_NUM > 1) ? $clog2(ADDER_NUM) : 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*WIDTH_SUM-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [WIDTH_S-1:0]  out_sum;
  logic [WIDTH_Q-1:0]         out_sumsq;
  logic [TW-1:0]              out_token;
  logic                       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum,
    output out_sumsq, out_token, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_sumsq, out_token, out_last
  );
endinterface

// File: rtl/residual_ln_stats.sv
// Per-token sum / sum-of-squares over residual beats (LANES elems/beat).
// Ports: clk, rst_n (async low), bus (slave: in_* beats, out_* records).
module residual_ln_stats #(
  parameter int ADDER_NUM = 128,
  parameter int DIMENTION = 768,
  parameter int WIDTH_SUM = 32,
  parameter int LANES     = 16
) (
  input logic               clk,
  input logic               rst_n,
  residual_ln_stats_if.slave bus
);
  localparam int BEATS = DIMENTION / LANES;
  localparam int WIDTH_S = WIDTH_SUM + $clog2(DIMENTION);
  localparam int WIDTH_Q = 2 * WIDTH_SUM + $clog2(DIMENTION);
  localparam int WIDTH_P = 2 * WIDTH_SUM;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = (ADDER_NUM > 1) ? $clog2(ADDER_NUM) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_TOK = TW'(ADDER_NUM - 1);

  logic signed [WIDTH_SUM-1:0] lane [LANES];
  logic signed [WIDTH_P-1:0]   sq   [LANES];
  logic signed [WIDTH_S-1:0]   beat_s, acc_s, sum_s;
  logic [WIDTH_Q-1:0]          beat_q, acc_q, sum_q;
  logic [BW-1:0]               beat_cnt;
  logic [TW-1:0]               token_cnt;
  logic                        last_beat, fire, fin;
  logic                        ov, ol;
  logic signed [WIDTH_S-1:0]   os;
  logic [WIDTH_Q-1:0]          oq;
  logic [TW-1:0]               ot;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      assign lane[k] = bus.in_data[k*WIDTH_SUM +: WIDTH_SUM];
      assign sq[k] = WIDTH_P'(lane[k]) * WIDTH_P'(lane[k]);
    end
  endgenerate

  always_comb begin
    beat_s = '0;
    beat_q = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_s = beat_s + WIDTH_S'(lane[i]);
      beat_q = beat_q + WIDTH_Q'($unsigned(sq[i]));
    end
  end

  // beat 0 restarts the accumulator directly: no clear bubble
  assign sum_s = (beat_cnt == '0) ? beat_s : acc_s + beat_s;
  assign sum_q = (beat_cnt == '0) ? beat_q : acc_q + beat_q;

  // only the final beat needs a free output slot
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign bus.in_ready = !(last_beat && ov && !bus.out_ready);
  assign fire = bus.in_valid && bus.in_ready;
  assign fin = fire && last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      token_cnt <= '0;
      acc_s <= '0;
      acc_q <= '0;
    end else if (fire) begin
      acc_s <= sum_s;
      acc_q <= sum_q;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (last_beat)
        token_cnt <= (token_cnt == LAST_TOK) ? '0 : token_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov <= 1'b0;
      os <= '0;
      oq <= '0;
      ot <= '0;
      ol <= 1'b0;
    end else begin
      if (fin) begin
        ov <= 1'b1;
        os <= sum_s;
        oq <= sum_q;
        ot <= token_cnt;
        ol <= (token_cnt == LAST_TOK);
      end else if (bus.out_ready) begin
        ov <= 1'b0;
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_sum = os;
  assign bus.out_sumsq = oq;
  assign bus.out_token = ot;
  assign bus.out_last = ol;
endmodule

// File: doc/residual_ln_stats.md
Name: residual_ln_stats

Overview:
- Streaming stage directly downstream of the per-token residual adder array; consumes the WIDTH_SUM-bit residual-sum elements, LANES elements per beat.
- Accumulates, per token, the signed sum and the unsigned sum of squares across all DIMENTION elements.
- Hands one statistics record per token to the LayerNorm mean/variance stage over a valid/ready interface.
- Tracks token index and flags the last token of a sequence of ADDER_NUM tokens.

Parameters:
- ADDER_NUM, 128: tokens per sequence; token index wraps at this value.
- DIMENTION, 768: elements per token.
- WIDTH_SUM, 32: signed element width, matching the adder's sum width.
- LANES, 16: elements per input beat; DIMENTION must be divisible by LANES, giving BEATS = DIMENTION/LANES = 48.
- WIDTH_S, WIDTH_SUM + clog2(DIMENTION) = 42: signed token-sum width.
- WIDTH_Q, 2*WIDTH_SUM + clog2(DIMENTION) = 74: unsigned sum-of-squares width.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_data, input, LANES*WIDTH_SUM: LANES signed elements; lane k is at [k*WIDTH_SUM +: WIDTH_SUM]; element order within a token is beat-major.
- out_valid, output, 1: statistics record valid.
- out_ready, input, 1: downstream accepts the record.
- out_sum, output, WIDTH_S: signed sum of the token's DIMENTION elements.
- out_sumsq, output, WIDTH_Q: unsigned sum of squares of the token's elements.
- out_token, output, clog2(ADDER_NUM): token index of the record.
- out_last, output, 1: record belongs to token ADDER_NUM-1.

Behaviour:
- Reset, asynchronous on rst_n low:
  - beat_cnt=0, token_cnt=0, acc_s=0, acc_q=0.
  - out_valid=0, out_sum=0, out_sumsq=0, out_token=0, out_last=0.
  - Reset mid-token discards the partial token; the next accepted beat is beat 0 of token 0.
- Beat handshake: a beat is accepted when in_valid && in_ready.
- Lane reduction is combinational from in_data:
  - beat_s = sign-extended sum of LANES elements.
  - beat_q = sum of LANES squares, each square computed as a signed product, non-negative, 2*WIDTH_SUM bits.
- Accumulation:
  - On accepting beat 0: acc_s <= beat_s, acc_q <= beat_q (no clear bubble).
  - On beats 1..BEATS-2: acc_s <= acc_s+beat_s, acc_q <= acc_q+beat_q.
  - beat_cnt increments on each accept and wraps to 0 after BEATS-1.
  - Arithmetic is exact. Widths are sized so no overflow is possible, including all elements at -2^(WIDTH_SUM-1).
- Final beat (beat_cnt==BEATS-1) accepted in cycle N:
  - out_sum <= acc_s+beat_s, out_sumsq <= acc_q+beat_q, out_token <= token_cnt, out_last <= (token_cnt==ADDER_NUM-1).
  - out_valid=1 from cycle N+1; latency is 1 cycle from last-beat accept.
  - token_cnt increments, wrapping to 0 after ADDER_NUM-1.
- Output hold: while out_valid && !out_ready, all out_* fields are stable. out_valid drops the cycle after out_valid && out_ready, unless a new final beat is accepted in that same cycle, in which case out_valid stays 1 with the new record.
- Backpressure:
  - in_ready = !(beat_cnt==BEATS-1 && out_valid && !out_ready), combinational.
  - Beats 0..BEATS-2 of the next token are always accepted, so the next token accumulates while the previous record is held.
  - Only the final beat stalls.
- Simultaneous final-beat accept and output handshake: the new record replaces the old one with no bubble and no loss. Sustained throughput is one token per BEATS cycles.
- No in_valid: all state holds.
- No FSM beyond beat_cnt/token_cnt/out_valid; the phase is fully defined by beat_cnt and out_valid.

Test Plan:
- Defaults, out_ready=1, one token with all elements 1 -> single record: out_sum=768, out_sumsq=768, out_token=0, out_last=0, out_valid high exactly 1 cycle after the 48th beat.
- All elements -2 -> out_sum=-1536, out_sumsq=3072.
- All elements -2^31 -> out_sum=-1649267441664, out_sumsq=768*2^62; no wrap, sign of out_sum correct.
- out_ready=0 after the first record, continuous in_valid -> next token's beats 0..46 accepted; in_ready low at beat 47 until out_ready=1. Then both records are delivered in order, and the first record stays stable while held.
- 128 tokens with element value = token index, random in_valid/out_ready gaps -> record t has out_sum=768*t and out_sumsq=768*t*t. out_token counts 0..127, out_last=1 only on token 127, and token 128 reports out_token=0.
- rst_n asserted after beat 20 of token 5 -> outputs zero immediately (asynchronous). The next 48 beats of all 3s yield out_sum=2304, out_sumsq=6912, out_token=0.
